// File: rtl/pipe_main_control.sv
// Main controller for the 5-stage pipeline: ID decode, load-use stall,
// flush bubbles and the ID/EX, EX/MEM, MEM/WB control registers.
module pipe_main_control #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2,
  parameter bit JAL_EN  = 1'b1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [5:0]         OPCODE,
  input  logic               ID_VALID,
  input  logic [REG_AW-1:0]  ID_RS,
  input  logic [REG_AW-1:0]  ID_RT,
  input  logic               FLUSH,
  output logic               STALL,
  output logic               ID_Jump,
  output logic [1:0]         EX_RegDst,
  output logic               EX_ALU_Src,
  output logic [ALUOP_W-1:0] EX_Alu_Op,
  output logic               EX_MemRead,
  output logic [REG_AW-1:0]  EX_RT,
  output logic               MEM_Branch,
  output logic               MEM_BranchNe,
  output logic               MEM_MemRead,
  output logic               MEM_MemWrite,
  output logic               WB_RegWrite,
  output logic [1:0]         WB_MemtoReg,
  output logic               ILLEGAL
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [ALUOP_W-1:0] ALU_ADD = '0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2);

  typedef struct packed {
    logic [1:0]         regdst;
    logic               alu_src;
    logic [ALUOP_W-1:0] aluop;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               branch_ne;
    logic               reg_write;
    logic [1:0]         mem_to_reg;
    logic [REG_AW-1:0]  rt;
  } ex_t;

  typedef struct packed {
    logic       branch;
    logic       branch_ne;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
  } mem_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] mem_to_reg;
  } wb_t;

  ex_t  dec;
  logic dec_jump;
  logic dec_legal;
  logic illegal;
  logic bubble;

  ex_t  ex_d, ex_q;
  mem_t mem_d, mem_q;
  wb_t  wb_d, wb_q;
  logic ill_d, ill_q;

  always_comb begin
    dec       = '0;
    dec_jump  = 1'b0;
    dec_legal = 1'b1;
    unique case (OPCODE)
      OP_R: begin
        dec.regdst    = 2'b01;
        dec.reg_write = 1'b1;
        dec.aluop     = ALU_FN;
      end
      OP_LW: begin
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 2'b01;
        dec.reg_write  = 1'b1;
        dec.aluop      = ALU_ADD;
      end
      OP_SW: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.aluop     = ALU_ADD;
      end
      OP_ADDI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.aluop     = ALU_ADD;
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.aluop  = ALU_SUB;
      end
      OP_BNE: begin
        dec.branch    = 1'b1;
        dec.branch_ne = 1'b1;
        dec.aluop     = ALU_SUB;
      end
      OP_J: dec_jump = 1'b1;
      OP_JAL: begin
        if (JAL_EN) begin
          dec_jump       = 1'b1;
          dec.regdst     = 2'b10;
          dec.mem_to_reg = 2'b10;
          dec.reg_write  = 1'b1;
        end else begin
          dec_legal = 1'b0;
        end
      end
      default: dec_legal = 1'b0;
    endcase
    dec.rt = ID_RT;
  end

  assign illegal = ID_VALID & ~dec_legal;

  // rt is compared for every opcode; a spurious stall only costs a cycle
  assign STALL = ex_q.mem_read & ID_VALID & (ex_q.rt != '0)
               & ((ex_q.rt == ID_RS) | (ex_q.rt == ID_RT))
               & ~FLUSH;

  assign ID_Jump = ID_VALID & dec_jump & ~STALL;

  assign bubble = FLUSH | STALL | ~ID_VALID | illegal;

  always_comb begin
    ex_d  = bubble ? '0 : dec;
    mem_d = '0;
    if (!FLUSH) begin
      mem_d.branch     = ex_q.branch;
      mem_d.branch_ne  = ex_q.branch_ne;
      mem_d.mem_read   = ex_q.mem_read;
      mem_d.mem_write  = ex_q.mem_write;
      mem_d.reg_write  = ex_q.reg_write;
      mem_d.mem_to_reg = ex_q.mem_to_reg;
    end
    wb_d.reg_write  = mem_q.reg_write;
    wb_d.mem_to_reg = mem_q.mem_to_reg;
    ill_d = ill_q | illegal;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      ill_q <= 1'b0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      ill_q <= ill_d;
    end
  end

  assign EX_RegDst    = ex_q.regdst;
  assign EX_ALU_Src   = ex_q.alu_src;
  assign EX_Alu_Op    = ex_q.aluop;
  assign EX_MemRead   = ex_q.mem_read;
  assign EX_RT        = ex_q.rt;
  assign MEM_Branch   = mem_q.branch;
  assign MEM_BranchNe = mem_q.branch_ne;
  assign MEM_MemRead  = mem_q.mem_read;
  assign MEM_MemWrite = mem_q.mem_write;
  assign WB_RegWrite  = wb_q.reg_write;
  assign WB_MemtoReg  = wb_q.mem_to_reg;
  assign ILLEGAL      = ill_q;

endmodule

// File: tb/tb_pipe_main_control.sv
// Directed bench for pipe_main_control: per-cycle vector table plus
// reset and JAL_EN=0 sequences.
module tb_pipe_main_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [5:0] opcode;
  logic       id_valid;
  logic [4:0] id_rs, id_rt;
  logic       flush;

  logic       stall, id_jump, ex_alu_src, ex_memread;
  logic [1:0] ex_regdst, ex_aluop, wb_memtoreg;
  logic [4:0] ex_rt;
  logic       mem_branch, mem_bne, mem_memread, mem_memwrite;
  logic       wb_regwrite, illegal;

  logic       j0_stall, j0_jump, j0_alu_src, j0_memread;
  logic [1:0] j0_regdst, j0_aluop, j0_memtoreg;
  logic [4:0] j0_rt;
  logic       j0_branch, j0_bne, j0_mem_memread, j0_mem_memwrite;
  logic       j0_regwrite, j0_illegal;

  always #5 CLK = ~CLK;

  pipe_main_control #(.REG_AW(5), .ALUOP_W(2), .JAL_EN(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .OPCODE(opcode), .ID_VALID(id_valid),
    .ID_RS(id_rs), .ID_RT(id_rt), .FLUSH(flush),
    .STALL(stall), .ID_Jump(id_jump), .EX_RegDst(ex_regdst),
    .EX_ALU_Src(ex_alu_src), .EX_Alu_Op(ex_aluop),
    .EX_MemRead(ex_memread), .EX_RT(ex_rt),
    .MEM_Branch(mem_branch), .MEM_BranchNe(mem_bne),
    .MEM_MemRead(mem_memread), .MEM_MemWrite(mem_memwrite),
    .WB_RegWrite(wb_regwrite), .WB_MemtoReg(wb_memtoreg),
    .ILLEGAL(illegal)
  );

  pipe_main_control #(.REG_AW(5), .ALUOP_W(2), .JAL_EN(1'b0)) dut_nojal (
    .CLK(CLK), .RST_N(RST_N), .OPCODE(opcode), .ID_VALID(id_valid),
    .ID_RS(id_rs), .ID_RT(id_rt), .FLUSH(flush),
    .STALL(j0_stall), .ID_Jump(j0_jump), .EX_RegDst(j0_regdst),
    .EX_ALU_Src(j0_alu_src), .EX_Alu_Op(j0_aluop),
    .EX_MemRead(j0_memread), .EX_RT(j0_rt),
    .MEM_Branch(j0_branch), .MEM_BranchNe(j0_bne),
    .MEM_MemRead(j0_mem_memread), .MEM_MemWrite(j0_mem_memwrite),
    .WB_RegWrite(j0_regwrite), .WB_MemtoReg(j0_memtoreg),
    .ILLEGAL(j0_illegal)
  );

  typedef struct {
    logic [5:0]  op;
    logic        v;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        fl;
    logic        stall;
    logic        jump;
    logic [10:0] ex;
    logic [3:0]  mem;
    logic [2:0]  wb;
    logic        ill;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [10:0] exv(input logic [1:0] rd, input logic s,
                                      input logic [1:0] op, input logic mr,
                                      input logic [4:0] rt);
    return {rd, s, op, mr, rt};
  endfunction

  function automatic vec_t row(
    input logic [5:0] op, input logic v, input logic [4:0] rs,
    input logic [4:0] rt, input logic fl, input logic st, input logic jp,
    input logic [10:0] ex, input logic [3:0] mem, input logic [2:0] wb,
    input logic ill);
    vec_t r;
    r.op = op; r.v = v; r.rs = rs; r.rt = rt; r.fl = fl;
    r.stall = st; r.jump = jp; r.ex = ex; r.mem = mem; r.wb = wb;
    r.ill = ill;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic v,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic fl);
    opcode = op; id_valid = v; id_rs = rs; id_rt = rt; flush = fl;
  endtask

  initial begin
    // R then lw then addi: no hazards, watch them walk to WB
    vq.push_back(row(OP_R,   1, 1, 2, 0, 0, 0, exv(1, 0, 2, 0, 2), 4'b0000, 3'b000, 0));
    vq.push_back(row(OP_LW,  1, 3, 4, 0, 0, 0, exv(0, 1, 0, 1, 4), 4'b0000, 3'b000, 0));
    vq.push_back(row(OP_ADDI,1, 6, 7, 0, 0, 0, exv(0, 1, 0, 0, 7), 4'b0010, 3'b100, 0));
    vq.push_back(row(OP_R,   0, 0, 0, 0, 0, 0, 11'd0,              4'b0000, 3'b101, 0));
    vq.push_back(row(OP_R,   0, 0, 0, 0, 0, 0, 11'd0,              4'b0000, 3'b100, 0));
    // load-use on rs
    vq.push_back(row(OP_LW,  1, 1, 5, 0, 0, 0, exv(0, 1, 0, 1, 5), 4'b0000, 3'b000, 0));
    vq.push_back(row(OP_R,   1, 5, 2, 0, 1, 0, 11'd0,              4'b0010, 3'b000, 0));
    vq.push_back(row(OP_R,   1, 5, 2, 0, 0, 0, exv(1, 0, 2, 0, 2), 4'b0000, 3'b101, 0));
    // load to r0 never stalls
    vq.push_back(row(OP_LW,  1, 1, 0, 0, 0, 0, exv(0, 1, 0, 1, 0), 4'b0000, 3'b000, 0));
    vq.push_back(row(OP_R,   1, 0, 0, 0, 0, 0, exv(1, 0, 2, 0, 0), 4'b0010, 3'b100, 0));
    // load-use on rt of a store
    vq.push_back(row(OP_LW,  1, 2, 9, 0, 0, 0, exv(0, 1, 0, 1, 9), 4'b0000, 3'b101, 0));
    vq.push_back(row(OP_SW,  1, 1, 9, 0, 1, 0, 11'd0,              4'b0010, 3'b100, 0));
    vq.push_back(row(OP_SW,  1, 1, 9, 0, 0, 0, exv(0, 1, 0, 0, 9), 4'b0000, 3'b101, 0));
    // beq reaches MEM, lw in EX, sw in ID with a hazard; flush wins
    vq.push_back(row(OP_BEQ, 1, 1, 2, 0, 0, 0, exv(0, 0, 1, 0, 2), 4'b0001, 3'b000, 0));
    vq.push_back(row(OP_LW,  1, 3, 4, 0, 0, 0, exv(0, 1, 0, 1, 4), 4'b1000, 3'b000, 0));
    vq.push_back(row(OP_SW,  1, 4, 8, 1, 0, 0, 11'd0,              4'b0000, 3'b000, 0));
    vq.push_back(row(OP_R,   0, 0, 0, 0, 0, 0, 11'd0,              4'b0000, 3'b000, 0));
    // jal, j, bne
    vq.push_back(row(OP_JAL, 1, 0, 0, 0, 0, 1, exv(2, 0, 0, 0, 0), 4'b0000, 3'b000, 0));
    vq.push_back(row(OP_J,   1, 0, 0, 0, 0, 1, 11'd0,              4'b0000, 3'b000, 0));
    vq.push_back(row(OP_R,   0, 0, 0, 0, 0, 0, 11'd0,              4'b0000, 3'b110, 0));
    vq.push_back(row(OP_BNE, 1, 1, 2, 0, 0, 0, exv(0, 0, 1, 0, 2), 4'b0000, 3'b000, 0));
    vq.push_back(row(OP_R,   0, 0, 0, 0, 0, 0, 11'd0,              4'b1100, 3'b000, 0));
    // a stalled jump must not redirect
    vq.push_back(row(OP_LW,  1, 0, 3, 0, 0, 0, exv(0, 1, 0, 1, 3), 4'b0000, 3'b000, 0));
    vq.push_back(row(OP_J,   1, 3, 0, 0, 1, 0, 11'd0,              4'b0010, 3'b000, 0));
    vq.push_back(row(OP_R,   0, 0, 0, 0, 0, 0, 11'd0,              4'b0000, 3'b101, 0));
    // illegal opcode, then sticky flag
    vq.push_back(row(OP_BAD, 1, 0, 0, 0, 0, 0, 11'd0,              4'b0000, 3'b000, 1));
    vq.push_back(row(OP_ADDI,1, 1, 2, 0, 0, 0, exv(0, 1, 0, 0, 2), 4'b0000, 3'b000, 1));
    vq.push_back(row(OP_R,   1, 1, 2, 0, 0, 0, exv(1, 0, 2, 0, 2), 4'b0000, 3'b000, 1));

    RST_N = 1'b0;
    drive(OP_R, 0, 0, 0, 0);
    #3;
    chk("reset_main", {stall, id_jump, ex_regdst, ex_alu_src, ex_aluop,
        ex_memread, ex_rt, mem_branch, mem_bne, mem_memread, mem_memwrite,
        wb_regwrite, wb_memtoreg, illegal}, 32'd0);
    chk("reset_nojal", {j0_stall, j0_jump, j0_regdst, j0_alu_src, j0_aluop,
        j0_memread, j0_rt, j0_branch, j0_bne, j0_mem_memread,
        j0_mem_memwrite, j0_regwrite, j0_memtoreg, j0_illegal}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].op, vq[i].v, vq[i].rs, vq[i].rt, vq[i].fl);
      #1;
      chk($sformatf("r%0d_stall", i), stall, vq[i].stall);
      chk($sformatf("r%0d_jump", i), id_jump, vq[i].jump);
      @(posedge CLK);
      #1;
      chk($sformatf("r%0d_ex", i),
          {ex_regdst, ex_alu_src, ex_aluop, ex_memread, ex_rt}, vq[i].ex);
      chk($sformatf("r%0d_mem", i),
          {mem_branch, mem_bne, mem_memread, mem_memwrite}, vq[i].mem);
      chk($sformatf("r%0d_wb", i), {wb_regwrite, wb_memtoreg}, vq[i].wb);
      chk($sformatf("r%0d_ill", i), illegal, vq[i].ill);
      @(negedge CLK);
    end

    // async reset with a store in MEM
    drive(OP_SW, 1, 1, 2, 0);
    @(posedge CLK);
    @(negedge CLK);
    drive(OP_R, 0, 0, 0, 0);
    @(posedge CLK);
    #2;
    chk("pre_rst_memwrite", mem_memwrite, 1'b1);
    chk("pre_rst_illegal", illegal, 1'b1);
    RST_N = 1'b0;
    #1;
    chk("async_rst_memwrite", mem_memwrite, 1'b0);
    chk("async_rst_illegal", illegal, 1'b0);
    chk("async_rst_all", {stall, id_jump, ex_regdst, ex_alu_src, ex_aluop,
        ex_memread, ex_rt, mem_branch, mem_bne, mem_memread, mem_memwrite,
        wb_regwrite, wb_memtoreg, illegal}, 32'd0);
    chk("async_rst_nojal", {j0_stall, j0_jump, j0_regdst, j0_alu_src,
        j0_aluop, j0_memread, j0_rt, j0_branch, j0_bne, j0_mem_memread,
        j0_mem_memwrite, j0_regwrite, j0_memtoreg, j0_illegal}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    drive(OP_R, 1, 1, 3, 0);
    @(posedge CLK);
    #1;
    chk("post_rst_ex", {ex_regdst, ex_aluop, ex_rt}, {2'b01, 2'b10, 5'd3});
    chk("post_rst_illegal", illegal, 1'b0);

    // jal with and without JAL_EN
    @(negedge CLK);
    drive(OP_JAL, 1, 0, 0, 0);
    #1;
    chk("jal_jump", id_jump, 1'b1);
    chk("nojal_jump", j0_jump, 1'b0);
    @(posedge CLK);
    #1;
    chk("jal_ex_regdst", ex_regdst, 2'b10);
    chk("nojal_ex_regdst", j0_regdst, 2'b00);
    chk("nojal_illegal", j0_illegal, 1'b1);
    chk("jal_illegal", illegal, 1'b0);
    @(negedge CLK);
    drive(OP_R, 0, 0, 0, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("jal_wb", {wb_regwrite, wb_memtoreg}, 3'b110);
    chk("nojal_wb", {j0_regwrite, j0_memtoreg}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
